// File: rtl/control_unit.sv
// Multi-cycle MIPS-subset control FSM: Moore outputs per state, with the
// branch PC write qualified by the live zero flag.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Flag_Zero,
  input  logic       Flag_Overflow,
  output logic       PC_W,
  output logic       Mem_W,
  output logic       MDR_W,
  output logic       IR_W,
  output logic       RB_W,
  output logic       Reg_AB_W,
  output logic       ALU_Out_Reg_W,
  output logic [2:0] ALUControl,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] exc
);

  typedef enum logic [4:0] {
    S_FETCH0    = 5'd0,
    S_FETCH1    = 5'd1,
    S_FETCH2    = 5'd2,
    S_DECODE    = 5'd3,
    S_R_EXEC    = 5'd4,
    S_R_WB      = 5'd5,
    S_ADDI_EXEC = 5'd6,
    S_ADDI_WB   = 5'd7,
    S_MEM_ADDR  = 5'd8,
    S_LW_RD0    = 5'd9,
    S_LW_RD1    = 5'd10,
    S_LW_RD2    = 5'd11,
    S_LW_WB     = 5'd12,
    S_SW_WR     = 5'd13,
    S_BRANCH    = 5'd14,
    S_JUMP      = 5'd15,
    S_EXC_OVF   = 5'd16,
    S_EXC_ILL   = 5'd17
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  state_e state_q, state_d;
  // lw/sw and beq/bne are resolved in DECODE and held, so later states
  // never look at the opcode again.
  logic   is_lw_q, is_lw_d;
  logic   is_bne_q, is_bne_d;

  logic funct_legal;
  logic funct_arith;

  always_comb begin
    funct_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
    funct_arith = (funct == FN_ADD) || (funct == FN_SUB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH0;
      is_lw_q  <= 1'b0;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_lw_q  <= is_lw_d;
      is_bne_q <= is_bne_d;
    end
  end

  always_comb begin
    state_d       = S_FETCH0;
    is_lw_d       = is_lw_q;
    is_bne_d      = is_bne_q;
    PC_W          = 1'b0;
    Mem_W         = 1'b0;
    MDR_W         = 1'b0;
    IR_W          = 1'b0;
    RB_W          = 1'b0;
    Reg_AB_W      = 1'b0;
    ALU_Out_Reg_W = 1'b0;
    ALUControl    = 3'b000;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemToReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'd0;
    PCSource      = 2'd0;
    exc           = 2'b00;

    case (state_q)
      S_FETCH0: begin
        ALUSrcB    = 2'd1;
        ALUControl = ALU_ADD;
        state_d    = S_FETCH1;
      end
      S_FETCH1: begin
        ALUSrcB    = 2'd1;
        ALUControl = ALU_ADD;
        state_d    = S_FETCH2;
      end
      S_FETCH2: begin
        ALUSrcB    = 2'd1;
        ALUControl = ALU_ADD;
        IR_W       = 1'b1;
        PC_W       = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        Reg_AB_W      = 1'b1;
        ALUSrcB       = 2'd3;
        ALUControl    = ALU_ADD;
        ALU_Out_Reg_W = 1'b1;
        is_lw_d       = (opcode == OP_LW);
        is_bne_d      = (opcode == OP_BNE);
        case (opcode)
          OP_RTYPE:      state_d = funct_legal ? S_R_EXEC : S_EXC_ILL;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_EXC_ILL;
        endcase
      end
      S_R_EXEC: begin
        ALUSrcA       = 1'b1;
        ALU_Out_Reg_W = 1'b1;
        case (funct)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          default: ALUControl = 3'b000;
        endcase
        state_d = (funct_arith && Flag_Overflow) ? S_EXC_OVF : S_R_WB;
      end
      S_R_WB: begin
        RegDst  = 1'b1;
        RB_W    = 1'b1;
        state_d = S_FETCH0;
      end
      S_ADDI_EXEC: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'd2;
        ALUControl    = ALU_ADD;
        ALU_Out_Reg_W = 1'b1;
        state_d       = Flag_Overflow ? S_EXC_OVF : S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RB_W    = 1'b1;
        state_d = S_FETCH0;
      end
      S_MEM_ADDR: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'd2;
        ALUControl    = ALU_ADD;
        ALU_Out_Reg_W = 1'b1;
        state_d       = is_lw_q ? S_LW_RD0 : S_SW_WR;
      end
      S_LW_RD0: begin
        IorD    = 1'b1;
        state_d = S_LW_RD1;
      end
      S_LW_RD1: begin
        IorD    = 1'b1;
        state_d = S_LW_RD2;
      end
      S_LW_RD2: begin
        IorD    = 1'b1;
        MDR_W   = 1'b1;
        state_d = S_LW_WB;
      end
      S_LW_WB: begin
        MemToReg = 1'b1;
        RB_W     = 1'b1;
        state_d  = S_FETCH0;
      end
      S_SW_WR: begin
        IorD    = 1'b1;
        Mem_W   = 1'b1;
        state_d = S_FETCH0;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSource   = 2'd1;
        PC_W       = is_bne_q ? ~Flag_Zero : Flag_Zero;
        state_d    = S_FETCH0;
      end
      S_JUMP: begin
        PCSource = 2'd2;
        PC_W     = 1'b1;
        state_d  = S_FETCH0;
      end
      S_EXC_OVF: begin
        exc     = 2'b01;
        state_d = S_FETCH0;
      end
      S_EXC_ILL: begin
        exc     = 2'b10;
        state_d = S_FETCH0;
      end
      default: state_d = S_FETCH0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench: each instruction is expanded by a per-cycle reference
// model into its expected control-word sequence and compared cycle by cycle.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       Flag_Zero, Flag_Overflow;
  logic       PC_W, Mem_W, MDR_W, IR_W, RB_W, Reg_AB_W, ALU_Out_Reg_W;
  logic [2:0] ALUControl;
  logic       IorD, RegDst, MemToReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, exc;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .Flag_Zero(Flag_Zero), .Flag_Overflow(Flag_Overflow),
    .PC_W(PC_W), .Mem_W(Mem_W), .MDR_W(MDR_W), .IR_W(IR_W), .RB_W(RB_W),
    .Reg_AB_W(Reg_AB_W), .ALU_Out_Reg_W(ALU_Out_Reg_W), .ALUControl(ALUControl),
    .IorD(IorD), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .exc(exc)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {PC_W, Mem_W, MDR_W, IR_W, RB_W, Reg_AB_W, ALU_Out_Reg_W, ALUControl,
                IorD, RegDst, MemToReg, ALUSrcA, ALUSrcB, PCSource, exc};

  // Control-word fields, same bit order as obs.
  localparam logic [19:0] W_PCW   = 20'h80000;
  localparam logic [19:0] W_MEMW  = 20'h40000;
  localparam logic [19:0] W_MDRW  = 20'h20000;
  localparam logic [19:0] W_IRW   = 20'h10000;
  localparam logic [19:0] W_RBW   = 20'h08000;
  localparam logic [19:0] W_RAB   = 20'h04000;
  localparam logic [19:0] W_AOW   = 20'h02000;
  localparam logic [19:0] W_ADD   = 20'h00400;
  localparam logic [19:0] W_SUB   = 20'h00800;
  localparam logic [19:0] W_AND   = 20'h00C00;
  localparam logic [19:0] W_IORD  = 20'h00200;
  localparam logic [19:0] W_RDST  = 20'h00100;
  localparam logic [19:0] W_M2R   = 20'h00080;
  localparam logic [19:0] W_SRCA  = 20'h00040;
  localparam logic [19:0] W_B4    = 20'h00010;
  localparam logic [19:0] W_BIMM  = 20'h00020;
  localparam logic [19:0] W_BIMM2 = 20'h00030;
  localparam logic [19:0] W_PCS1  = 20'h00004;
  localparam logic [19:0] W_PCS2  = 20'h00008;
  localparam logic [19:0] W_EOVF  = 20'h00001;
  localparam logic [19:0] W_EILL  = 20'h00002;

  localparam logic [19:0] E_FETCH = W_B4 | W_ADD;
  localparam logic [19:0] E_ALUI  = W_SRCA | W_BIMM | W_ADD | W_AOW;

  int errors = 0;
  int checks = 0;

  logic [19:0] exp_q[$];
  bit          zf[1:12];
  bit          ovf[1:12];

  task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%05h expected=%05h", tag, got, expv);
    end
  endtask

  // Expected control word for every cycle of one instruction, from FETCH0 on.
  function automatic void build_expect(input logic [5:0] op, input logic [5:0] fn);
    logic [19:0] alu;
    exp_q.delete();
    exp_q.push_back(E_FETCH);
    exp_q.push_back(E_FETCH);
    exp_q.push_back(E_FETCH | W_IRW | W_PCW);
    exp_q.push_back(W_RAB | W_BIMM2 | W_ADD | W_AOW);
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) begin
          alu = (fn == 6'h20) ? W_ADD : (fn == 6'h22) ? W_SUB : W_AND;
          exp_q.push_back(W_SRCA | alu | W_AOW);
          if (fn != 6'h24 && ovf[5]) exp_q.push_back(W_EOVF);
          else exp_q.push_back(W_RDST | W_RBW);
        end else begin
          exp_q.push_back(W_EILL);
        end
      end
      6'h08: begin
        exp_q.push_back(E_ALUI);
        exp_q.push_back(ovf[5] ? W_EOVF : W_RBW);
      end
      6'h23: begin
        exp_q.push_back(E_ALUI);
        exp_q.push_back(W_IORD);
        exp_q.push_back(W_IORD);
        exp_q.push_back(W_IORD | W_MDRW);
        exp_q.push_back(W_M2R | W_RBW);
      end
      6'h2B: begin
        exp_q.push_back(E_ALUI);
        exp_q.push_back(W_IORD | W_MEMW);
      end
      6'h04: exp_q.push_back(W_SRCA | W_SUB | W_PCS1 | (zf[5] ? W_PCW : 20'h0));
      6'h05: exp_q.push_back(W_SRCA | W_SUB | W_PCS1 | (zf[5] ? 20'h0 : W_PCW));
      6'h02: exp_q.push_back(W_PCS2 | W_PCW);
      default: exp_q.push_back(W_EILL);
    endcase
  endfunction

  // Run one instruction; abort_at > 0 asserts reset during that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input bit z5, input bit o5, input int abort_at);
    int n;
    for (int k = 1; k <= 12; k++) begin
      zf[k]  = 1'($urandom_range(0, 1));
      ovf[k] = 1'($urandom_range(0, 1));
    end
    zf[5]  = z5;
    ovf[5] = o5;
    build_expect(op, fn);
    n = exp_q.size();
    $display("instr op=%02h funct=%02h zf=%0d ovf=%0d cycles=%0d abort_at=%0d",
             op, fn, z5, o5, n, abort_at);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      // The instruction register only holds this instruction from DECODE on.
      if (k <= 3) begin
        opcode = 6'($urandom_range(0, 63));
        funct  = 6'($urandom_range(0, 63));
      end else begin
        opcode = op;
        funct  = fn;
      end
      Flag_Zero     = zf[k];
      Flag_Overflow = ovf[k];
      reset         = (k == abort_at);
      #1;
      check_eq($sformatf("op%02h_fn%02h_c%0d", op, fn, k), obs, exp_q[k-1]);
      if (k == abort_at) break;
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    reset = 1'b1;
    opcode = 6'h00; funct = 6'h00;
    Flag_Zero = 1'b0; Flag_Overflow = 1'b0;
    @(negedge clk); #1;
    check_eq("reset_0", obs, E_FETCH);
    @(negedge clk);
    opcode = 6'h23; Flag_Overflow = 1'b1; Flag_Zero = 1'b1;
    #1;
    check_eq("reset_1", obs, E_FETCH);

    run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0);
    run_instr(6'h00, 6'h22, 1'b0, 1'b1, 0);
    run_instr(6'h00, 6'h24, 1'b0, 1'b1, 0);
    run_instr(6'h00, 6'h2A, 1'b0, 1'b0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 1'b1, 0);
    run_instr(6'h2B, 6'h11, 1'b1, 1'b1, 0);
    run_instr(6'h04, 6'h00, 1'b1, 1'b0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, 0);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0, 0);
    run_instr(6'h05, 6'h00, 1'b0, 1'b0, 0);
    run_instr(6'h08, 6'h00, 1'b0, 1'b1, 0);
    run_instr(6'h08, 6'h00, 1'b0, 1'b0, 0);
    run_instr(6'h3F, 6'h20, 1'b0, 1'b0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, 7);
    run_instr(6'h02, 6'h00, 1'b0, 1'b0, 0);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 7))
        0: op = 6'h00;
        1: op = 6'h08;
        2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h04;
        5: op = 6'h05;
        6: op = 6'h02;
        default: op = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 3))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("final_fetch0", obs, E_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
